// File: rtl/simple_axi_pkg.sv
// Shared definitions for the simple AXI slave RAM: response codes, size
// encodings, the controller state enum and the per-transaction decode.
package simple_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2,
        R_DATA = 2'd3
    } state_t;

    // Response for a request; span is the decoded window size in bytes.
    // 33-bit compare so a window ending at 4 GiB does not wrap.
    function automatic logic [1:0] decode_resp(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [32:0] lo;
        logic [32:0] hi;
        logic [31:0] mask;
        logic [1:0]  resp;
        lo   = {1'b0, base};
        hi   = lo + span;
        mask = (32'd1 << size) - 32'd1;
        resp = RESP_OKAY;
        if (({1'b0, addr} < lo) || ({1'b0, addr} >= hi)) begin
            resp = RESP_DECERR;
        end else if ((size > SIZE_D) || ((addr & mask) != 32'd0) || (len != 8'd0)) begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

endpackage

// File: rtl/simple_axi_slave_ram_if.sv
// AXI4 bus bundle between the simple AXI master and the slave RAM.
interface simple_axi_slave_ram_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic        awid;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awlock;
    logic [3:0]  awqos;
    logic [3:0]  awregion;

    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic        arid;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arlock;
    logic [3:0]  arqos;
    logic [3:0]  arregion;

    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rid;

    modport master (
        output awvalid, awaddr, awsize, awlen, awid,
               awburst, awcache, awprot, awlock, awqos, awregion,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arsize, arlen, arid,
               arburst, arcache, arprot, arlock, arqos, arregion,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awsize, awlen, awid,
               awburst, awcache, awprot, awlock, awqos, awregion,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arsize, arlen, arid,
               arburst, arcache, arprot, arlock, arqos, arregion,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/simple_axi_slave_ram_mem.sv
// Byte-strobed single-port RAM, MEM_DWORDS x 64, synchronous read.
// Built as eight byte-wide lanes so each lane maps onto its own block RAM
// write enable. Read returns the old contents on a simultaneous write.
module simple_axi_slave_ram_mem #(
    parameter int unsigned MEM_DWORDS = 512,
    parameter int unsigned AW         = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic [7:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DWORDS];
            logic [7:0] lane_rdata_reg;

            // Per-lane write with strobe, registered read of the addressed byte.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        lane_mem[addr] <= wdata[gi*8 +: 8];
                    end
                    lane_rdata_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate
endmodule

// File: rtl/simple_axi_slave_ram.sv
// AXI4 slave backed by a 64-bit RAM; one transaction at a time.
// Decodes range/alignment, applies write strobes, returns OKAY/SLVERR/DECERR
// and echoes the request ID. Bursts are accepted but answered with SLVERR.
// Optional macro SIMPLE_AXI_SLAVE_RAM_WAIT_EN adds RESP_DELAY idle cycles
// before the B response and before the first R beat.
module simple_axi_slave_ram
    import simple_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MEM_DWORDS = 512,
    parameter int unsigned RESP_DELAY = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    simple_axi_slave_ram_if.slave   s_axi
);
    localparam int unsigned AW   = $clog2(MEM_DWORDS);
    localparam logic [32:0] SPAN = 33'(MEM_DWORDS) << 3;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [7:0]  len_reg, len_next;
    logic        id_reg, id_next;
    logic [1:0]  resp_reg, resp_next;
    logic [7:0]  beat_reg, beat_next;
    logic        wr_first_reg, wr_first_next;

    logic        aw_ready, ar_ready, w_ready, b_valid, r_valid;
    logic        wait_done;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [31:0] mem_offset;
    logic [63:0] mem_rdata;

`ifdef SIMPLE_AXI_SLAVE_RAM_WAIT_EN
    logic [15:0] wait_reg, wait_next;

    // Reload the delay on entry to a response state, otherwise count down to 0.
    always_comb begin
        wait_next = (wait_reg != 16'd0) ? (wait_reg - 16'd1) : 16'd0;
        if ((state_next != state_reg) && ((state_next == W_RESP) || (state_next == R_DATA))) begin
            wait_next = 16'(RESP_DELAY);
        end
    end

    // Delay counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_reg <= 16'd0;
        end else begin
            wait_reg <= wait_next;
        end
    end

    assign wait_done = (wait_reg == 16'd0);
`else
    assign wait_done = 1'b1;
`endif

    // Arbitration, handshakes, beat counting and next-state selection.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        len_next      = len_reg;
        id_next       = id_reg;
        resp_next     = resp_reg;
        beat_next     = beat_reg;
        wr_first_next = wr_first_reg;
        aw_ready      = 1'b0;
        ar_ready      = 1'b0;
        w_ready       = 1'b0;
        b_valid       = 1'b0;
        r_valid       = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 8'h00;
        mem_offset    = addr_reg - BASE_ADDR;

        case (state_reg)
            IDLE: begin
                // A lone request is always granted; a tie goes to wr_first_reg.
                aw_ready   = !s_axi.arvalid || (s_axi.awvalid && wr_first_reg);
                ar_ready   = !s_axi.awvalid || (s_axi.arvalid && !wr_first_reg);
                mem_offset = s_axi.araddr - BASE_ADDR;
                if (s_axi.awvalid && aw_ready) begin
                    addr_next     = s_axi.awaddr;
                    len_next      = s_axi.awlen;
                    id_next       = s_axi.awid;
                    resp_next     = decode_resp(s_axi.awaddr, s_axi.awsize, s_axi.awlen, BASE_ADDR, SPAN);
                    beat_next     = 8'd0;
                    wr_first_next = 1'b0;
                    state_next    = W_DATA;
                end else if (s_axi.arvalid && ar_ready) begin
                    // Start the RAM read now so data is ready on the first R cycle.
                    addr_next     = s_axi.araddr;
                    len_next      = s_axi.arlen;
                    id_next       = s_axi.arid;
                    resp_next     = decode_resp(s_axi.araddr, s_axi.arsize, s_axi.arlen, BASE_ADDR, SPAN);
                    beat_next     = 8'd0;
                    wr_first_next = 1'b1;
                    mem_en        = 1'b1;
                    state_next    = R_DATA;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (s_axi.wvalid) begin
                    if ((beat_reg == 8'd0) && (resp_reg == RESP_OKAY)) begin
                        mem_en = 1'b1;
                        mem_we = s_axi.wstrb;
                    end
                    // A misplaced wlast flags the burst but never shortens it.
                    if (s_axi.wlast != (beat_reg == len_reg)) begin
                        resp_next = RESP_SLVERR;
                    end
                    if (beat_reg == len_reg) begin
                        beat_next  = 8'd0;
                        state_next = W_RESP;
                    end else begin
                        beat_next = beat_reg + 8'd1;
                    end
                end
            end
            W_RESP: begin
                b_valid = wait_done;
                if (b_valid && s_axi.bready) begin
                    state_next = IDLE;
                end
            end
            R_DATA: begin
                // Only the first beat waits for the delay counter.
                r_valid = (beat_reg != 8'd0) || wait_done;
                if (r_valid && s_axi.rready) begin
                    if (beat_reg == len_reg) begin
                        beat_next  = 8'd0;
                        state_next = IDLE;
                    end else begin
                        beat_next = beat_reg + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (i_rst) begin
            aw_ready = 1'b0;
            ar_ready = 1'b0;
            w_ready  = 1'b0;
            b_valid  = 1'b0;
            r_valid  = 1'b0;
        end
    end

    // Controller state and captured request fields.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            addr_reg     <= 32'd0;
            len_reg      <= 8'd0;
            id_reg       <= 1'b0;
            resp_reg     <= RESP_OKAY;
            beat_reg     <= 8'd0;
            wr_first_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            id_reg       <= id_next;
            resp_reg     <= resp_next;
            beat_reg     <= beat_next;
            wr_first_reg <= wr_first_next;
        end
    end

    simple_axi_slave_ram_mem #(
        .MEM_DWORDS (MEM_DWORDS),
        .AW         (AW)
    ) u_mem (
        .clk   (i_clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_offset[AW+2:3]),
        .wdata (s_axi.wdata),
        .rdata (mem_rdata)
    );

    assign s_axi.awready = aw_ready;
    assign s_axi.arready = ar_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bresp   = resp_reg;
    assign s_axi.bid     = id_reg;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rresp   = resp_reg;
    assign s_axi.rid     = id_reg;
    assign s_axi.rlast   = r_valid && (beat_reg == len_reg);
    // RAM output holds for the whole read because the RAM is idle in R_DATA.
    assign s_axi.rdata   = ((state_reg == R_DATA) && (resp_reg == RESP_OKAY)) ? mem_rdata : 64'd0;

    // Sideband fields and address bits outside the word index carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi.awburst, s_axi.awcache, s_axi.awprot, s_axi.awlock,
                             s_axi.awqos, s_axi.awregion, s_axi.arburst, s_axi.arcache,
                             s_axi.arprot, s_axi.arlock, s_axi.arqos, s_axi.arregion,
                             mem_offset[31:AW+3], mem_offset[2:0], RESP_DELAY[0]};

endmodule

// File: doc/simple_axi_slave_ram.md
Name: simple_axi_slave_ram

Overview:
- AXI4 slave (responder) backed by an internal 64-bit-wide RAM.
- It is the far end of the simple AXI master: the bench, and small SoC configs, connect master m_axi_* directly to its s_axi_* ports.
- Services one transaction at a time (write or read).
- Decodes address range and alignment, applies write strobes, and returns OKAY/SLVERR/DECERR responses with the request ID echoed.

Parameters:
- BASE_ADDR, 32'h0000_0000, first byte address decoded.
- MEM_DWORDS, 512, RAM depth in 64-bit words (power of two).
- RESP_DELAY, 4, extra idle cycles before B/R response; used only with the optional feature.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- s_axi_awvalid/awready  in/out  1/1  AW handshake.
- s_axi_awaddr  input  32  write address.
- s_axi_awsize  input  3  beat size.
- s_axi_awlen  input  8  beats minus one.
- s_axi_awid  input  1  write ID.
- s_axi_awburst/awcache/awprot/awlock/awqos/awregion  input  2/4/3/1/4/4  ignored.
- s_axi_wvalid/wready  in/out  1/1  W handshake.
- s_axi_wdata  input  64  write data.
- s_axi_wstrb  input  8  byte enables.
- s_axi_wlast  input  1  final beat.
- s_axi_bvalid/bready  out/in  1/1  B handshake.
- s_axi_bresp  output  2  write response.
- s_axi_bid  output  1  echoed awid.
- s_axi_arvalid/arready  in/out  1/1  AR handshake.
- s_axi_araddr  input  32  read address.
- s_axi_arsize  input  3  beat size.
- s_axi_arlen  input  8  beats minus one.
- s_axi_arid  input  1  read ID.
- s_axi_arburst/arcache/arprot/arlock/arqos/arregion  input  2/4/3/1/4/4  ignored.
- s_axi_rvalid/rready  out/in  1/1  R handshake.
- s_axi_rdata  output  64  read data.
- s_axi_rresp  output  2  read response.
- s_axi_rlast  output  1  final read beat.
- s_axi_rid  output  1  echoed arid.

Behaviour:
- One clock and a synchronous active-high reset. Reset forces state IDLE and clears every valid/ready output; all other outputs reset to 0. RAM contents are not reset.
- Reset mid-transaction abandons the transaction silently.
- States are IDLE, W_DATA, W_RESP, R_DATA.
- IDLE:
  - awready and arready are both high combinationally while in IDLE, gated by arbitration.
  - If only one of awvalid/arvalid is high, that one is granted.
  - If both are high, grant alternates starting with write after reset (1-bit last-grant flag). Only the granted ready is driven high.
  - On AW handshake, capture addr, size, len and id, compute the response code, and go to W_DATA.
  - On AR handshake, capture the same fields and go to R_DATA.
- Response code, evaluated once per transaction:
  - DECERR (2'b11) if addr < BASE_ADDR or addr >= BASE_ADDR + 8*MEM_DWORDS.
  - Else SLVERR (2'b10) if size > 3, or addr is not aligned to 2^size, or len != 0.
  - Else OKAY.
- W_DATA:
  - wready is high; the block accepts len+1 beats, counted by an 8-bit beat counter.
  - On the first beat, if the response is OKAY, write the RAM word at (addr - BASE_ADDR) >> 3 with byte lanes enabled by wstrb.
  - A wlast value mismatched to the beat count forces SLVERR and does not end the burst early.
  - After the final beat go to W_RESP.
- W_RESP: bvalid is high, bresp holds the captured code and bid holds awid. bvalid stays asserted until bready. Then return to IDLE.
- R_DATA:
  - The RAM read is registered; rvalid rises the cycle after the AR handshake, giving 1-cycle latency.
  - len+1 beats are returned. rdata is the full aligned RAM word for OKAY, and 64'h0 for errors.
  - rlast is high only on beat len. rresp and rid are held stable while rvalid && !rready.
  - After the final handshake return to IDLE.
- Outputs on each channel are stable while valid is high and ready is low.

Optional Feature:
- Macro: SIMPLE_AXI_SLAVE_RAM_WAIT_EN.
- Defined: a 16-bit down-counter loads RESP_DELAY on entry to W_RESP and R_DATA. bvalid, and rvalid for the first beat only, stay low until the counter reaches 0.
- Undefined: no counter, and the latencies are as specified above.

Decomposition:
- Shared package simple_axi_pkg holds:
  - response constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - size encodings SIZE_B/H/W/D;
  - the state enum.
- Sub-module simple_axi_slave_ram_mem: byte-strobed, single-port, synchronous-read RAM (MEM_DWORDS x 64).

Test Plan:
- Dword write: 0x10 with wdata 0x1122334455667788 and wstrb FF, then read 0x10 -> bresp 0, rdata 0x1122334455667788, rresp 0, rlast 1.
- Byte write: 0x13, size 0, wdata 0xAB<<24, wstrb 0x08 over 0 -> read 0x10 returns 0x00000000AB000000.
- Misaligned: write 0x12 with size 2 -> bresp 2'b10 and the RAM is unchanged on a subsequent read. Read 0x11 with size 1 -> rresp 2'b10, rdata 0.
- Out of range: read BASE_ADDR + 8*MEM_DWORDS -> rresp 2'b11, rid equals arid=1.
- Burst rejection: arlen 3 -> 4 beats of SLVERR with rlast only on the 4th. awlen 1 -> both W beats accepted, then a single bresp 2'b10.
- Simultaneous AW and AR for two consecutive rounds -> write granted first, then read. With rready/bready held low 5 cycles -> outputs stable, no lost response.
